// File: rtl/period_meter_pkg.sv
// Shared types and defaults for the pulse-train period meter.
package period_meter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        RUN   = 2'd2
    } state_t;

    // Stall threshold shared with the fare logic.
    localparam int unsigned DEFAULT_TIMEOUT = 50_000_000;

endpackage

// File: rtl/period_meter_sync_rise.sv
// Synchronises the asynchronous pulse input and flags its rising edges.
module sync_rise #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sig_in,
    output logic s_sync,
    output logic rise
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s_prev;

    always_ff @(posedge clk) begin
        if (rst_n) begin
            sync_q <= '0;
            s_prev <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], sig_in};
            s_prev <= sync_q[SYNC_STAGES-1];
        end
    end

    assign s_sync = sync_q[SYNC_STAGES-1];
    assign rise   = s_sync & ~s_prev;

endmodule

// File: rtl/period_meter.sv
// Measures period and high time of a pulse train in clk cycles, flags stalls
// and keeps a wrapping rising-edge count.
module period_meter
    import period_meter_pkg::*;
#(
    parameter int unsigned WIDTH       = 32,
    parameter int unsigned TIMEOUT     = DEFAULT_TIMEOUT,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned EDGE_W      = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              sig_in,
    output logic [WIDTH-1:0]  period,
    output logic [WIDTH-1:0]  high_time,
    output logic              valid,
    output logic              stalled,
    output logic [EDGE_W-1:0] edge_cnt
);

    localparam logic [WIDTH-1:0] CNT_LAST = WIDTH'(TIMEOUT - 1);

    logic             s_sync;
    logic             rise;
    state_t           state;
    logic [WIDTH-1:0] cnt;
    logic [WIDTH-1:0] hcnt;

    sync_rise #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync_rise (
        .clk    (clk),
        .rst_n  (rst_n),
        .sig_in (sig_in),
        .s_sync (s_sync),
        .rise   (rise)
    );

    // Counters and measurement FSM; a rise always takes priority over timeout.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            hcnt      <= '0;
            period    <= '0;
            high_time <= '0;
            valid     <= 1'b0;
            stalled   <= 1'b0;
            edge_cnt  <= '0;
        end else begin
            valid <= 1'b0;
            if (rise) begin
                edge_cnt <= edge_cnt + EDGE_W'(1);
            end
            case (state)
                IDLE: begin
                    if (rise) begin
                        state <= ARMED;
                        cnt   <= '0;
                        hcnt  <= WIDTH'(1);
                    end
                end
                ARMED, RUN: begin
                    if (rise) begin
                        period    <= cnt + WIDTH'(1);
                        high_time <= hcnt;
                        valid     <= 1'b1;
                        stalled   <= 1'b0;
                        state     <= RUN;
                        cnt       <= '0;
                        hcnt      <= WIDTH'(1);
                    end else if (cnt == CNT_LAST) begin
                        // Counters park at zero in IDLE so cnt never passes TIMEOUT-1.
                        stalled <= 1'b1;
                        state   <= IDLE;
                        cnt     <= '0;
                        hcnt    <= '0;
                    end else begin
                        cnt  <= cnt + WIDTH'(1);
                        hcnt <= hcnt + WIDTH'(s_sync);
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                    hcnt  <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_period_meter.sv
// Scoreboard bench for period_meter with TIMEOUT=100 and a 4-bit edge counter.
module tb_period_meter;

    localparam int unsigned WIDTH   = 32;
    localparam int unsigned TIMEOUT = 100;
    localparam int unsigned EDGE_W  = 4;

    logic              clk = 1'b0;
    logic              rst_n = 1'b1;
    logic              sig_in = 1'b0;
    logic [WIDTH-1:0]  period;
    logic [WIDTH-1:0]  high_time;
    logic              valid;
    logic              stalled;
    logic [EDGE_W-1:0] edge_cnt;

    typedef struct {
        logic [WIDTH-1:0] p;
        logic [WIDTH-1:0] h;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    exp_t push_e;

    int checks = 0;
    int failures = 0;

    bit                armed = 1'b0;
    int                prev_gap = 0;
    int                prev_h = 0;
    int                last_p = 0;
    int                last_h = 0;
    logic [EDGE_W-1:0] exp_edges = '0;
    logic              prev_valid = 1'b0;

    period_meter #(
        .WIDTH       (WIDTH),
        .TIMEOUT     (TIMEOUT),
        .SYNC_STAGES (2),
        .EDGE_W      (EDGE_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .sig_in    (sig_in),
        .period    (period),
        .high_time (high_time),
        .valid     (valid),
        .stalled   (stalled),
        .edge_cnt  (edge_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    // Pops one expected measurement per valid pulse.
    always @(negedge clk) begin
        if (rst_n === 1'b0) begin
            if (valid === 1'b1) begin
                checks++;
                if (sb.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_valid period=%0d high_time=%0d at %0t",
                             period, high_time, $time);
                end else begin
                    mon_e = sb.pop_front();
                    if (period !== mon_e.p || high_time !== mon_e.h || stalled !== 1'b0
                        || prev_valid !== 1'b0) begin
                        failures++;
                        $display("FAIL measurement got p=%0d h=%0d st=%0b pv=%0b exp p=%0d h=%0d st=0 pv=0 at %0t",
                                 period, high_time, stalled, prev_valid, mon_e.p, mon_e.h, $time);
                    end
                end
            end
            prev_valid = valid;
        end else begin
            prev_valid = 1'b0;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic model_rise();
        exp_edges = exp_edges + EDGE_W'(1);
        if (armed && prev_gap <= int'(TIMEOUT)) begin
            push_e.p = WIDTH'(prev_gap);
            push_e.h = WIDTH'(prev_h);
            sb.push_back(push_e);
            last_p = prev_gap;
            last_h = prev_h;
        end
        armed = 1'b1;
    endtask

    // One waveform cycle: h cycles high then l cycles low, starting at a drive point.
    task automatic pulse(input int h, input int l);
        model_rise();
        sig_in = 1'b1;
        repeat (h) step();
        sig_in = 1'b0;
        repeat (l) step();
        prev_gap = h + l;
        prev_h   = h;
        checks++;
        if (edge_cnt !== exp_edges) begin
            failures++;
            $display("FAIL edge_cnt got=%0d exp=%0d at %0t", edge_cnt, exp_edges, $time);
        end
    endtask

    task automatic check_drained(input string name);
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL %s missing_valids got=%0d exp=0", name, sb.size());
            sb.delete();
        end
    endtask

    task automatic check_zero(input string name);
        checks++;
        if (period !== '0 || high_time !== '0 || valid !== 1'b0 || stalled !== 1'b0
            || edge_cnt !== '0) begin
            failures++;
            $display("FAIL %s outputs p=%0d h=%0d v=%0b st=%0b ec=%0d exp all 0",
                     name, period, high_time, valid, stalled, edge_cnt);
        end
    endtask

    task automatic test_reset();
        rst_n  = 1'b1;
        sig_in = 1'b0;
        step();
        @(negedge clk);
        check_zero("reset");
        step();
        step();
        rst_n = 1'b0;
        step();
        check_zero("post_reset_idle");
    endtask

    task automatic test_square();
        for (int i = 0; i < 6; i++) pulse(5, 5);
        check_drained("square");
        checks++;
        if (period !== WIDTH'(10) || high_time !== WIDTH'(5) || stalled !== 1'b0) begin
            failures++;
            $display("FAIL square_hold got p=%0d h=%0d st=%0b exp p=10 h=5 st=0",
                     period, high_time, stalled);
        end
    endtask

    task automatic test_switch();
        for (int i = 0; i < 5; i++) pulse(3, 4);
        check_drained("switch");
    endtask

    task automatic test_stall();
        model_rise();
        sig_in = 1'b1;
        for (int k = 1; k <= 150; k++) begin
            step();
            if (k == 3) sig_in = 1'b0;
            if (k == 102) begin
                @(negedge clk);
                checks++;
                if (stalled !== 1'b0) begin
                    failures++;
                    $display("FAIL stall_early got=%0b exp=0", stalled);
                end
            end
            if (k == 103) begin
                @(negedge clk);
                checks++;
                if (stalled !== 1'b1 || period !== WIDTH'(last_p) || high_time !== WIDTH'(last_h)) begin
                    failures++;
                    $display("FAIL stall_onset got st=%0b p=%0d h=%0d exp st=1 p=%0d h=%0d",
                             stalled, period, high_time, last_p, last_h);
                end
            end
        end
        prev_gap = 150;
        prev_h   = 3;
        pulse(5, 5);
        checks++;
        if (stalled !== 1'b1) begin
            failures++;
            $display("FAIL stall_after_arm got=%0b exp=1", stalled);
        end
        pulse(5, 5);
        checks++;
        if (stalled !== 1'b0) begin
            failures++;
            $display("FAIL stall_cleared got=%0b exp=0", stalled);
        end
        check_drained("stall");
    endtask

    task automatic test_exact_timeout();
        pulse(10, 90);
        pulse(10, 90);
        pulse(5, 5);
        checks++;
        if (stalled !== 1'b0) begin
            failures++;
            $display("FAIL exact_timeout_stalled got=%0b exp=0", stalled);
        end
        check_drained("exact_timeout");
    endtask

    task automatic test_reset_mid();
        pulse(5, 2);
        rst_n  = 1'b1;
        sig_in = 1'b1;
        step();
        @(negedge clk);
        check_zero("reset_mid");
        step();
        step();
        rst_n = 1'b0;
        sb.delete();
        armed     = 1'b0;
        exp_edges = '0;
        pulse(4, 4);
        pulse(5, 5);
        pulse(5, 5);
        check_drained("reset_mid");
    endtask

    task automatic test_edge_wrap();
        for (int i = 0; i < 17; i++) pulse(2, 3);
        check_drained("edge_wrap");
    endtask

    initial begin
        test_reset();
        test_square();
        test_switch();
        test_stall();
        test_exact_timeout();
        test_reset_mid();
        test_edge_wrap();
        repeat (5) step();
        check_drained("final");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
